exec_action_sequencer: RTL and testbench

//  Buffers parser actions (shift/reduce) from the LR driver and issues them one at a time to exec.

---
 rtl/exec_action_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_exec_action_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_action_sequencer.sv
// ---------------------------------------------------------------------------
// exec_action_sequencer
//
// Purpose:
//   Buffers shift/reduce actions coming from the LR driver and hands them to
//   exec one at a time. Each action sits in an issue register until exec
//   acknowledges it with EX_RECEIVE. After a reduce is received, the block
//   inserts GAP_CYCLES idle cycles so exec's registered result push cannot
//   collide with the push caused by a following shift. Actions carrying
//   data 0 are discarded, because exec cannot tell them apart from "no action".
//
// Optional feature (compile-time macro):
//   ACTSEQ_TIMEOUT_EN - adds a 16-bit issue timeout. If EX_RECEIVE does not
//                       arrive within TIMEOUT_CYCLES issue cycles, the block
//                       locks into an error state until RST. When the macro is
//                       undefined the issue state waits forever and O_ERROR=0.
//
// Parameters:
//   DEPTH_LOG2     - action FIFO holds 2**DEPTH_LOG2 entries
//   GAP_CYCLES     - idle cycles after a received reduce (>= 1)
//   TIMEOUT_CYCLES - issue cycles allowed before error (timeout build only)
//
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   I_VALID      - upstream action valid (transfer when I_VALID && O_READY)
//   I_KIND       - 0 = shift, 1 = reduce
//   I_DATA       - shift token word / reduce production number
//   I_LAST       - final action of a program
//   O_READY      - FIFO can accept an action
//   EX_VALID     - action presented to exec
//   EX_SHIFT     - shift word (0 unless a shift is presented)
//   EX_REDUCE    - production number (0 unless a reduce is presented)
//   EX_RECEIVE   - exec acknowledge, same cycle as EX_VALID
//   O_COUNT      - FIFO occupancy
//   O_DONE       - 1-cycle pulse when an I_LAST entry retires or is dropped
//   O_DROP       - 1-cycle pulse when a zero-data entry is discarded
//   O_ERROR      - sticky timeout flag
// ---------------------------------------------------------------------------
module exec_action_sequencer #(
  parameter int DEPTH_LOG2     = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_VALID,
  input  logic                  I_KIND,
  input  logic [15:0]           I_DATA,
  input  logic                  I_LAST,
  output logic                  O_READY,
  output logic                  EX_VALID,
  output logic [15:0]           EX_SHIFT,
  output logic [15:0]           EX_REDUCE,
  input  logic                  EX_RECEIVE,
  output logic [DEPTH_LOG2:0]   O_COUNT,
  output logic                  O_DONE,
  output logic                  O_DROP,
  output logic                  O_ERROR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Illegal parameter combinations stop elaboration.
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("exec_action_sequencer: GAP_CYCLES and TIMEOUT_CYCLES must be in range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_ERROR} state_t;

  state_t                r_state;
  state_t                w_state_next;

  // FIFO entry layout: {LAST, KIND, DATA}
  logic [17:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [17:0]           w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_retire;

  // Issue register
  logic                  r_kind;
  logic                  r_last;
  logic [15:0]           r_data;

  logic [GW-1:0]         r_gap_cnt;
  logic                  r_done;
  logic                  r_drop;

`ifdef ACTSEQ_TIMEOUT_EN
  logic [15:0]           r_to_cnt;
`endif

  assign w_full  = r_count[DEPTH_LOG2];   // occupancy never exceeds DEPTH
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_push  = I_VALID && O_READY;

  // Next-state and pop/retire decisions
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[15:0] == '0) begin
            w_drop = 1'b1;
          end else begin
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (EX_RECEIVE) begin
          w_retire     = 1'b1;
          w_state_next = r_kind ? S_GAP : S_IDLE;
        end
`ifdef ACTSEQ_TIMEOUT_EN
        else if (r_to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = S_ERROR;
        end
`endif
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        // S_ERROR is left only through RST.
        w_state_next = r_state;
      end
    endcase
  end

  // FIFO storage: no reset, so it maps onto RAM primitives.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {I_LAST, I_KIND, I_DATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_kind    <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop && !w_drop) begin
        {r_last, r_kind, r_data} <= w_head;
      end
      if (w_retire && r_kind) begin
        r_gap_cnt <= GW'(GAP_CYCLES - 1);
      end else if (r_state == S_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
      r_drop <= w_drop;
      r_done <= (w_drop && w_head[17]) || (w_retire && r_last);
    end
  end

`ifdef ACTSEQ_TIMEOUT_EN
  // Counts issue cycles that went by without an acknowledge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (w_pop && !w_drop) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE && !EX_RECEIVE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
  assign O_ERROR = (r_state == S_ERROR);
`else
  assign O_ERROR = 1'b0;
`endif

  assign O_READY   = !w_full && (r_state != S_ERROR);
  assign EX_VALID  = (r_state == S_ISSUE);
  assign EX_SHIFT  = (EX_VALID && !r_kind) ? r_data : '0;
  assign EX_REDUCE = (EX_VALID &&  r_kind) ? r_data : '0;
  assign O_COUNT   = r_count;
  assign O_DONE    = r_done;
  assign O_DROP    = r_drop;

endmodule

// File: tb/tb_exec_action_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_action_sequencer
//
// Directed stimulus with hand-computed expectations, plus a transaction-level
// model (action queue, "busy with one action" flag, gap hold-off counter)
// that predicts every output on every cycle once reset has been applied.
// ---------------------------------------------------------------------------
module tb_exec_action_sequencer;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam int GAP   = 1;
  localparam int TMO   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_kind = 1'b0;
  logic          i_last = 1'b0;
  logic [15:0]   i_data = '0;
  logic          o_ready;
  logic          ex_valid;
  logic [15:0]   ex_shift;
  logic [15:0]   ex_reduce;
  logic          ex_receive;
  logic [DL2:0]  o_count;
  logic          o_done;
  logic          o_drop;
  logic          o_error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // exec stand-in: acknowledges once EX_VALID has been high rx_delay cycles.
  int rx_delay  = 0;
  int valid_run = 0;
  int rx_total  = 0;

  always #5 clk = ~clk;

  assign ex_receive = ex_valid && (valid_run >= rx_delay);

  always @(posedge clk) begin
    if (ex_valid && !ex_receive) valid_run <= valid_run + 1;
    else                         valid_run <= 0;
    if (ex_valid && ex_receive)  rx_total  <= rx_total + 1;
  end

  exec_action_sequencer #(
    .DEPTH_LOG2    (DL2),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .I_VALID   (i_valid),
    .I_KIND    (i_kind),
    .I_DATA    (i_data),
    .I_LAST    (i_last),
    .O_READY   (o_ready),
    .EX_VALID  (ex_valid),
    .EX_SHIFT  (ex_shift),
    .EX_REDUCE (ex_reduce),
    .EX_RECEIVE(ex_receive),
    .O_COUNT   (o_count),
    .O_DONE    (o_done),
    .O_DROP    (o_drop),
    .O_ERROR   (o_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  logic [17:0] m_q[$];
  logic [17:0] m_cur;
  bit          m_busy;
  int          m_hold;
  bit          m_done;
  bit          m_drop;
  bit          m_err;
  int          m_issue_n;

  function automatic bit m_ready();
    return (m_q.size() < DEPTH) && !m_err;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur     = '0;
    m_busy    = 1'b0;
    m_hold    = 0;
    m_done    = 1'b0;
    m_drop    = 1'b0;
    m_err     = 1'b0;
    m_issue_n = 0;
  endtask

  task automatic model_step();
    bit          push;
    bit          nd;
    bit          ndr;
    logic [17:0] e;
    push = i_valid && m_ready();
    nd   = 1'b0;
    ndr  = 1'b0;
    if (m_err) begin
      // locked until reset
    end else if (m_busy) begin
      if (ex_receive) begin
        m_busy = 1'b0;
        nd     = m_cur[17];
        if (m_cur[16]) m_hold = GAP;
      end else begin
`ifdef ACTSEQ_TIMEOUT_EN
        m_issue_n++;
        if (m_issue_n >= TMO) begin
          m_err  = 1'b1;
          m_busy = 1'b0;
        end
`endif
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      if (e[15:0] == 16'h0) begin
        ndr = 1'b1;
        nd  = e[17];
      end else begin
        m_busy    = 1'b1;
        m_cur     = e;
        m_issue_n = 0;
      end
    end
    if (push) m_q.push_back({i_last, i_kind, i_data});
    m_done = nd;
    m_drop = ndr;
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ex_valid",  ex_valid,  m_busy);
      chk("model_ex_shift",  ex_shift,  (m_busy && !m_cur[16]) ? m_cur[15:0] : 16'h0);
      chk("model_ex_reduce", ex_reduce, (m_busy &&  m_cur[16]) ? m_cur[15:0] : 16'h0);
      chk("model_o_ready",   o_ready,   m_ready());
      chk("model_o_count",   o_count,   m_q.size());
      chk("model_o_done",    o_done,    m_done);
      chk("model_o_drop",    o_drop,    m_drop);
      chk("model_o_error",   o_error,   m_err);
    end
    if (rst) model_reset();
    else     model_step();
  end

  // ------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit k, input bit l, input logic [15:0] d);
    i_valid = v;
    i_kind  = k;
    i_last  = l;
    i_data  = d;
  endtask

  initial begin
    int r0;
    model_reset();
    rst = 1'b1;
    step(2);
    chk("rst_ready", o_ready, 1);
    chk("rst_count", o_count, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_shift", ex_shift, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_error", o_error, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    step(1);

    // Single shift, acknowledged immediately
    rx_delay = 0;
    drive(1, 0, 0, 16'h0005); step();
    drive(0, 0, 0, 16'h0000); step();
    chk("t1_valid_c2",  ex_valid, 1);
    chk("t1_shift_c2",  ex_shift, 16'h0005);
    chk("t1_reduce_c2", ex_reduce, 0);
    step();
    chk("t1_valid_c3",  ex_valid, 0);
    step(2);

    // Reduce held for 3 cycles, one gap cycle, then a shift
    rx_delay = 2;
    drive(1, 1, 0, 16'h0008); step();
    drive(1, 0, 0, 16'h0003); step();
    drive(0, 0, 0, 16'h0000);
    chk("t2_reduce_c2", ex_reduce, 8);
    step();
    chk("t2_reduce_c3", ex_reduce, 8);
    chk("t2_norecv_c3", ex_receive, 0);
    step();
    chk("t2_reduce_c4", ex_reduce, 8);
    chk("t2_recv_c4",   ex_receive, 1);
    step();
    chk("t2_gap_c5",    ex_valid, 0);
    step();
    chk("t2_idle_c6",   ex_valid, 0);
    rx_delay = 0;
    step();
    chk("t2_valid_c7",  ex_valid, 1);
    chk("t2_shift_c7",  ex_shift, 16'h0003);
    chk("t2_reduce_c7", ex_reduce, 0);
    step(3);

    // Fill: 17 shifts while exec never acknowledges
    rx_delay = 1000;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 16'(i + 1));
      chk("t3_ready_fill", o_ready, 1);
      step();
    end
    drive(1, 0, 0, 16'h00AA);   // offered while full: must be refused
    chk("t3_ready_full", o_ready, 0);
    chk("t3_count_full", o_count, 16);
    chk("t3_issue_head", ex_shift, 16'h0001);
    step();
    drive(0, 0, 0, 16'h0000);
    chk("t3_count_hold", o_count, 16);
    r0 = rx_total;
    rx_delay = 0;
    step(40);
    chk("t3_retired", rx_total - r0, 17);
    chk("t3_drained", o_count, 0);

    // Zero-data action with LAST is dropped
    drive(1, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'h0000);
    chk("t4_drop_c1",  o_drop, 0);
    step();
    chk("t4_drop_c2",  o_drop, 1);
    chk("t4_done_c2",  o_done, 1);
    chk("t4_valid_c2", ex_valid, 0);
    step();
    chk("t4_drop_c3",  o_drop, 0);
    chk("t4_done_c3",  o_done, 0);
    step(2);

    // Reset during the gap with three entries queued
    rx_delay = 1;
    drive(1, 1, 0, 16'h0009); step();
    drive(1, 0, 0, 16'h0011); step();
    drive(1, 0, 0, 16'h0012); step();
    drive(1, 0, 0, 16'h0013); step();
    drive(0, 0, 0, 16'h0000);
    chk("t6_gap_valid", ex_valid, 0);
    chk("t6_gap_count", o_count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_count", o_count, 0);
    chk("t6_rst_valid", ex_valid, 0);
    chk("t6_rst_ready", o_ready, 1);
    step(3);

`ifdef ACTSEQ_TIMEOUT_EN
    // Issue timeout locks the block until reset
    rx_delay = 1000;
    drive(1, 0, 0, 16'h0007); step();
    drive(0, 0, 0, 16'h0000);
    step(4);
    chk("t5_noerr_c5", o_error, 0);
    step();
    chk("t5_error",    o_error, 1);
    chk("t5_valid",    ex_valid, 0);
    chk("t5_ready",    o_ready, 0);
    drive(1, 0, 0, 16'h0021); step();
    drive(0, 0, 0, 16'h0000);
    chk("t5_no_push",  o_count, 0);
    chk("t5_sticky",   o_error, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rx_delay = 0;
    chk("t5_rst_err",  o_error, 0);
    chk("t5_rst_rdy",  o_ready, 1);
    step(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
